// File: rtl/y86_fetch_pkg.sv
// -----------------------------------------------------------------------------
// y86_fetch_pkg
// Shared definitions for the Y86-64 fetch sequencer:
//   - default address width and highest legal fetch address
//   - icode encodings (HALT .. POPQ)
//   - fetch FSM state enum
//   - sticky error status codes
// -----------------------------------------------------------------------------
package y86_fetch_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int MAX_PC_DEF = 200;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_ADR = 2'd1;
    localparam logic [1:0] ERR_INS = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_OP      = 3'd1,
        S_REG     = 3'd2,
        S_CONST   = 3'd3,
        S_PRESENT = 3'd4,
        S_HALT    = 3'd5,
        S_ERR     = 3'd6
    } fetch_state_t;

endpackage

// File: rtl/fetch_len_decode.sv
// -----------------------------------------------------------------------------
// fetch_len_decode
// Combinational classification of a Y86-64 icode.
// Ports:
//   icode     in  4  instruction code (byte0 high nibble)
//   len       out 4  instruction length in bytes (1, 2, 9 or 10)
//   has_reg   out 1  instruction carries a register-specifier byte
//   has_const out 1  instruction carries an 8-byte constant
//   legal     out 1  icode is a defined instruction (0..B)
// -----------------------------------------------------------------------------
module fetch_len_decode
    import y86_fetch_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       has_reg,
    output logic       has_const,
    output logic       legal
);

    always_comb begin
        len       = 4'd1;
        has_reg   = 1'b0;
        has_const = 1'b0;
        legal     = 1'b1;
        case (icode)
            I_HALT, I_NOP, I_RET: ;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                len     = 4'd2;
                has_reg = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                len       = 4'd10;
                has_reg   = 1'b1;
                has_const = 1'b1;
            end
            I_JXX, I_CALL: begin
                len       = 4'd9;
                has_const = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Multi-cycle Y86-64 fetch controller. Owns the PC, reads a byte-wide
// instruction memory one byte per request and assembles icode/ifun/rA/rB/
// valC/valP for decode. Honours decode backpressure, execute redirects,
// halt and address/instruction errors.
//
// Optional feature: define FETCH_SEQ_JMP_PREDICT_EN to load the PC with valC
// on acceptance of an unconditional jmp (icode 7 / ifun 0) or call (icode 8).
// Without it the PC always advances to valP.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, start_pc        begin fetching at start_pc (IDLE only)
//   imem_req, imem_addr    byte read request / address
//   imem_rvalid, imem_rdata read data return
//   redirect_valid/_pc     execute-stage redirect, highest priority
//   out_valid, out_ready   decode handshake
//   icode, ifun, rA, rB    instruction fields (rA/rB = F when no reg byte)
//   valC                   big-endian constant, 0 when none
//   valP, pc_out           next sequential PC / instruction PC
//   halted                 sticky, set when a halt is accepted
//   err                    sticky status: 0 ok, 1 address, 2 instruction
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start
// S_OP      | fetching byte0 (icode/ifun)
// S_REG     | fetching register-specifier byte
// S_CONST   | fetching constant bytes, cnt = 0..7
// S_PRESENT | fields complete; out_valid raised, waiting for decode
// S_HALT    | halt accepted, terminal until reset
// S_ERR     | address or instruction error, terminal until reset
// -----------------------------------------------------------------------------
module fetch_sequencer
    import y86_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int MAX_PC = MAX_PC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [7:0]        imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic [1:0]        err
);

    fetch_state_t      state;
    fetch_state_t      lat_next;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        offset;
    logic [2:0]        cnt;
    logic              req_q;
    logic              drop;
    logic              has_const_q;
    logic              lat_more;

    logic [3:0]        dec_len;
    logic              dec_has_reg;
    logic              dec_has_const;
    logic              dec_legal;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              cur_bad;
    logic              next_bad;
    logic              busy;
    logic [ADDR_W-1:0] next_pc;

    fetch_len_decode u_len_decode (
        .icode     (imem_rdata[7:4]),
        .len       (dec_len),
        .has_reg   (dec_has_reg),
        .has_const (dec_has_const),
        .legal     (dec_legal)
    );

    // Request is dropped in the cycle its data returns; the next byte of the
    // same instruction is requested in the following cycle at the new address,
    // giving two cycles per byte.
    assign imem_req = req_q & ~imem_rvalid;

    assign cur_addr  = pc + ADDR_W'(offset);
    assign next_addr = cur_addr + ADDR_W'(1);
    assign cur_bad   = cur_addr > ADDR_W'(MAX_PC);
    assign next_bad  = next_addr > ADDR_W'(MAX_PC);
    assign busy      = (state == S_OP) || (state == S_REG) ||
                       (state == S_CONST) || (state == S_PRESENT);

`ifdef FETCH_SEQ_JMP_PREDICT_EN
    assign next_pc = (((icode == I_JXX) && (ifun == 4'h0)) || (icode == I_CALL))
                     ? valC[ADDR_W-1:0] : valP;
`else
    assign next_pc = valP;
`endif

    // Where to go after the byte being latched this cycle.
    always_comb begin
        lat_more = 1'b0;
        lat_next = S_PRESENT;
        case (state)
            S_OP: begin
                if (dec_legal && (dec_len != 4'd1)) begin
                    lat_more = 1'b1;
                    lat_next = dec_has_reg ? S_REG : S_CONST;
                end
            end
            S_REG: begin
                if (has_const_q) begin
                    lat_more = 1'b1;
                    lat_next = S_CONST;
                end
            end
            S_CONST: begin
                if (cnt != 3'd7) begin
                    lat_more = 1'b1;
                    lat_next = S_CONST;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            offset      <= '0;
            cnt         <= '0;
            req_q       <= 1'b0;
            drop        <= 1'b0;
            has_const_q <= 1'b0;
            imem_addr   <= '0;
            out_valid   <= 1'b0;
            icode       <= '0;
            ifun        <= '0;
            rA          <= REG_NONE;
            rB          <= REG_NONE;
            valC        <= '0;
            valP        <= '0;
            pc_out      <= '0;
            halted      <= 1'b0;
            err         <= ERR_OK;
        end else if (busy && redirect_valid) begin
            pc        <= redirect_pc;
            state     <= S_OP;
            offset    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            req_q     <= 1'b0;
            // A request already accepted by memory will still return data;
            // remember to discard it before fetching at the new PC.
            drop      <= (drop | req_q) & ~imem_rvalid;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc     <= start_pc;
                        state  <= S_OP;
                        offset <= '0;
                        cnt    <= '0;
                    end
                end
                S_OP, S_REG, S_CONST: begin
                    if (drop) begin
                        if (imem_rvalid) drop <= 1'b0;
                    end else if (!req_q) begin
                        if (cur_bad) begin
                            state <= S_ERR;
                            err   <= ERR_ADR;
                        end else begin
                            req_q     <= 1'b1;
                            imem_addr <= cur_addr;
                        end
                    end else if (imem_rvalid) begin
                        case (state)
                            S_OP: begin
                                icode       <= imem_rdata[7:4];
                                ifun        <= imem_rdata[3:0];
                                rA          <= REG_NONE;
                                rB          <= REG_NONE;
                                valC        <= '0;
                                pc_out      <= pc;
                                valP        <= pc + ADDR_W'(dec_len);
                                has_const_q <= dec_has_const;
                            end
                            S_REG: begin
                                rA <= imem_rdata[7:4];
                                rB <= imem_rdata[3:0];
                            end
                            default: begin
                                valC <= {valC[55:0], imem_rdata};
                                cnt  <= cnt + 3'd1;
                            end
                        endcase
                        if ((state == S_OP) && !dec_legal) begin
                            state <= S_ERR;
                            err   <= ERR_INS;
                            req_q <= 1'b0;
                        end else if (!lat_more) begin
                            state <= S_PRESENT;
                            req_q <= 1'b0;
                        end else if (next_bad) begin
                            state <= S_ERR;
                            err   <= ERR_ADR;
                            req_q <= 1'b0;
                        end else begin
                            state     <= lat_next;
                            offset    <= offset + 4'd1;
                            imem_addr <= next_addr;
                        end
                    end
                end
                S_PRESENT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        pc        <= next_pc;
                        offset    <= '0;
                        cnt       <= '0;
                        if (icode == I_HALT) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state <= S_OP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] start_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [7:0]  imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pc_out;
    logic        halted;
    logic [1:0]  err;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_sequencer #(.ADDR_W(64), .MAX_PC(200)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_pc       (start_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .icode          (icode),
        .ifun           (ifun),
        .rA             (rA),
        .rB             (rB),
        .valC           (valC),
        .valP           (valP),
        .pc_out         (pc_out),
        .halted         (halted),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Byte memory with configurable latency; one request outstanding.
    logic [7:0]  mem [0:255];
    int          mem_lat = 1;
    logic        busy_m = 1'b0;
    logic [63:0] a_m = '0;
    int          cnt_m = 0;

    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (busy_m) begin
            if (cnt_m == 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem[a_m[7:0]];
                busy_m      <= 1'b0;
            end else begin
                cnt_m <= cnt_m - 1;
            end
        end else if (imem_req) begin
            if (mem_lat <= 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem[imem_addr[7:0]];
            end else begin
                busy_m <= 1'b1;
                a_m    <= imem_addr;
                cnt_m  <= mem_lat - 2;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [63:0] pc);
        start_pc = pc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_req(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (imem_req) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({imem_req, out_valid, halted, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req/ov/halted/err got %b exp 00000", {imem_req, out_valid, halted, err});
        end
        n_tests++;
        if ({icode, ifun, rA, rB} !== 16'h00FF) begin
            n_fail++;
            $display("FAIL reset_fields: got %h exp 00ff", {icode, ifun, rA, rB});
        end
        n_tests++;
        if ({valC, valP, pc_out, imem_addr} !== 256'd0) begin
            n_fail++;
            $display("FAIL reset_values: valC %h valP %h pc_out %h addr %h exp all 0", valC, valP, pc_out, imem_addr);
        end
    endtask

    task automatic test_irmovq();
        int t_req, t_ov;
        do_reset();
        mem_lat = 1;
        mem[0] = 8'h30; mem[1] = 8'h02;
        for (int i = 2; i < 9; i++) mem[i] = 8'h00;
        mem[9] = 8'h10;
        pulse_start(64'd0);
        t_req = -1; t_ov = -1;
        for (int i = 0; i < 80; i++) begin
            if (imem_req && t_req < 0) t_req = i;
            if (out_valid) begin t_ov = i; break; end
            @(negedge clk);
        end
        n_tests++;
        if (t_req < 0 || t_ov < 0 || (t_ov - t_req) != 21) begin
            n_fail++;
            $display("FAIL irmovq_latency: first req %0d out_valid %0d, exp 21 cycles apart", t_req, t_ov);
        end
        n_tests++;
        if ({icode, ifun, rA, rB} !== 16'h3002) begin
            n_fail++;
            $display("FAIL irmovq_fields: got %h exp 3002", {icode, ifun, rA, rB});
        end
        n_tests++;
        if ({valC, valP, pc_out} !== {64'h10, 64'd10, 64'd0}) begin
            n_fail++;
            $display("FAIL irmovq_vals: valC %h valP %0d pc_out %0d exp 10/10/0", valC, valP, pc_out);
        end
        handshake();
        begin
            bit ok;
            wait_req(20, ok);
            n_tests++;
            if (!ok || imem_addr !== 64'd10) begin
                n_fail++;
                $display("FAIL irmovq_next_pc: req %0b addr %0d exp 1/10", ok, imem_addr);
            end
        end
    endtask

    task automatic test_jmp_addq();
        bit ok;
        do_reset();
        mem_lat = 1;
        mem[30] = 8'h70;
        for (int i = 31; i < 38; i++) mem[i] = 8'h00;
        mem[38] = 8'h27;
        mem[39] = 8'h60; mem[40] = 8'h03; mem[41] = 8'h10;
        pulse_start(64'd30);
        wait_valid(60, ok);
        n_tests++;
        if (!ok || {icode, ifun, rA, rB} !== 16'h70FF) begin
            n_fail++;
            $display("FAIL jmp_fields: valid %0b got %h exp 70ff", ok, {icode, ifun, rA, rB});
        end
        n_tests++;
        if ({valC, valP, pc_out} !== {64'd39, 64'd39, 64'd30}) begin
            n_fail++;
            $display("FAIL jmp_vals: valC %0d valP %0d pc_out %0d exp 39/39/30", valC, valP, pc_out);
        end
        handshake();
        wait_req(20, ok);
        n_tests++;
        if (!ok || imem_addr !== 64'd39) begin
            n_fail++;
            $display("FAIL jmp_next_req: req %0b addr %0d exp 1/39", ok, imem_addr);
        end
        wait_valid(40, ok);
        n_tests++;
        if (!ok || {icode, ifun, rA, rB, valC, valP, pc_out} !== {16'h6003, 64'd0, 64'd41, 64'd39}) begin
            n_fail++;
            $display("FAIL addq_fields: valid %0b fields %h valC %h valP %0d pc_out %0d exp 6003/0/41/39",
                     ok, {icode, ifun, rA, rB}, valC, valP, pc_out);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if ({out_valid, imem_req, icode, ifun, rA, rB, valP} !== {1'b1, 1'b0, 16'h6003, 64'd41}) begin
                n_fail++;
                $display("FAIL addq_stall_c%0d: ov %0b req %0b fields %h valP %0d exp 1/0/6003/41",
                         c, out_valid, imem_req, {icode, ifun, rA, rB}, valP);
            end
        end
        handshake();
        wait_req(20, ok);
        n_tests++;
        if (!ok || imem_addr !== 64'd41) begin
            n_fail++;
            $display("FAIL addq_next_req: req %0b addr %0d exp 1/41", ok, imem_addr);
        end
    endtask

    task automatic test_redirect();
        bit ok;
        bit seen_ov;
        do_reset();
        mem_lat = 3;
        mem[50] = 8'h30; mem[51] = 8'hF1;
        for (int i = 52; i < 60; i++) mem[i] = 8'h60;
        mem[122] = 8'h10;
        pulse_start(64'd50);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (imem_req && imem_addr == 64'd52) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL redirect_setup: const request at 52 not seen, addr %0d", imem_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 64'd122;
        @(negedge clk);
        redirect_valid = 1'b0;
        seen_ov = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen_ov |= out_valid;
            if (imem_req) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++;
        if (!ok || imem_addr !== 64'd122 || seen_ov) begin
            n_fail++;
            $display("FAIL redirect_req: req %0b addr %0d out_valid_seen %0b exp 1/122/0", ok, imem_addr, seen_ov);
        end
        wait_valid(40, ok);
        n_tests++;
        if (!ok || {icode, ifun, rA, rB, valC, valP, pc_out} !== {16'h10FF, 64'd0, 64'd123, 64'd122}) begin
            n_fail++;
            $display("FAIL redirect_fields: valid %0b fields %h valP %0d pc_out %0d exp 10ff/123/122",
                     ok, {icode, ifun, rA, rB}, valP, pc_out);
        end
        mem_lat = 1;
    endtask

    task automatic test_errors();
        bit ok, seen_req, seen_ov;
        do_reset();
        mem_lat = 1;
        mem[60] = 8'hC0;
        pulse_start(64'd60);
        for (int i = 0; i < 20 && err == 2'd0; i++) @(negedge clk);
        n_tests++;
        if ({err, out_valid} !== {2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL ins_err: err %0d out_valid %0b exp 2/0", err, out_valid);
        end
        seen_req = 1'b0; seen_ov = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen_req |= imem_req; seen_ov |= out_valid;
        end
        n_tests++;
        if ({seen_req, seen_ov, err} !== {1'b0, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL ins_err_quiet: req %0b ov %0b err %0d exp 0/0/2", seen_req, seen_ov, err);
        end

        do_reset();
        pulse_start(64'd201);
        seen_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen_req |= imem_req;
            @(negedge clk);
        end
        n_tests++;
        if ({seen_req, err} !== {1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL adr_err_start: req_seen %0b err %0d exp 0/1", seen_req, err);
        end

        do_reset();
        mem[200] = 8'h10;
        pulse_start(64'd200);
        wait_valid(20, ok);
        n_tests++;
        if (!ok || {icode, pc_out, valP, err} !== {4'h1, 64'd200, 64'd201, 2'd0}) begin
            n_fail++;
            $display("FAIL max_pc_fetch: valid %0b icode %0d pc_out %0d valP %0d err %0d exp 1/200/201/0",
                     ok, icode, pc_out, valP, err);
        end
        handshake();
        seen_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen_req |= imem_req;
            @(negedge clk);
        end
        n_tests++;
        if ({seen_req, err} !== {1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL adr_err_wrap: req_seen %0b err %0d exp 0/1", seen_req, err);
        end
    endtask

    task automatic test_halt();
        bit ok, seen_req, seen_ov;
        do_reset();
        mem_lat = 1;
        mem[70] = 8'h00;
        pulse_start(64'd70);
        wait_valid(20, ok);
        n_tests++;
        if (!ok || {icode, halted, valP} !== {4'h0, 1'b0, 64'd71}) begin
            n_fail++;
            $display("FAIL halt_present: valid %0b icode %0d halted %0b valP %0d exp 1/0/0/71", ok, icode, halted, valP);
        end
        handshake();
        n_tests++;
        if ({halted, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL halt_accept: halted %0b out_valid %0b exp 1/0", halted, out_valid);
        end
        start_pc = 64'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_req = 1'b0; seen_ov = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen_req |= imem_req; seen_ov |= out_valid;
            @(negedge clk);
        end
        n_tests++;
        if ({seen_req, seen_ov, halted} !== 3'b001) begin
            n_fail++;
            $display("FAIL halt_terminal: req %0b ov %0b halted %0b exp 0/0/1", seen_req, seen_ov, halted);
        end
    endtask

    task automatic test_reset_midfetch();
        bit ok, seen_req, seen_ov;
        do_reset();
        mem_lat = 3;
        mem[0] = 8'h30;
        pulse_start(64'd0);
        wait_req(20, ok);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({imem_req, out_valid, halted, err, icode, ifun, rA, rB, imem_addr, valP, pc_out}
            !== {5'b0, 16'h00FF, 64'd0, 64'd0, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_midfetch: req %0b ov %0b fields %h addr %0d exp 0/0/00ff/0",
                     imem_req, out_valid, {icode, ifun, rA, rB}, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_req = 1'b0; seen_ov = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen_req |= imem_req; seen_ov |= out_valid;
        end
        n_tests++;
        if ({seen_req, seen_ov, err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_inflight: req %0b ov %0b err %0d exp 0/0/0", seen_req, seen_ov, err);
        end
        mem_lat = 1;
        mem[70] = 8'h00;
        pulse_start(64'd70);
        wait_valid(20, ok);
        n_tests++;
        if (!ok || {icode, pc_out} !== {4'h0, 64'd70}) begin
            n_fail++;
            $display("FAIL reset_restart: valid %0b icode %0d pc_out %0d exp 1/0/70", ok, icode, pc_out);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h10;
        test_reset();
        test_irmovq();
        test_jmp_addq();
        test_redirect();
        test_errors();
        test_halt();
        test_reset_midfetch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
